// File: rtl/pattern_mem_generator.sv
// rtl/pattern_mem_generator.sv - RGB565 test-pattern frame-buffer byte source
// answering the display controller's mem_req/mem_addr byte-read handshake.
module pattern_mem_generator #(
  parameter int          FB_WIDTH      = 80,
  parameter int          FB_HEIGHT     = 60,
  parameter int          NUM_COLORS    = 12,
  parameter int          LATENCY       = 1,
  parameter int          CHECKER_SHIFT = 3,
  parameter int          ADDR_WIDTH    = 32,
  parameter logic [15:0] ERROR_COLOR   = 16'hF81F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mode,
  input  logic                  animate,
  input  logic [15:0]           solid_color,
  output logic [7:0]            mem_out,
  output logic                  mem_ready,
  output logic                  seq_error,
  output logic [15:0]           frame_count
);

  localparam int ROWS_PER_BAND = FB_HEIGHT / NUM_COLORS;
  localparam int COLS_PER_BAND = FB_WIDTH / NUM_COLORS;
  localparam int FRAME_BYTES   = 2 * FB_WIDTH * FB_HEIGHT;
  localparam int XW            = $clog2(FB_WIDTH + 1);
  localparam int YW            = $clog2(FB_HEIGHT + 1);
  localparam int CW            = $clog2(NUM_COLORS + 1);
  localparam int CW1           = CW + 1;

  typedef enum logic [1:0] {SYNC, RUN, ERROR} state_t;

  state_t                state, state_next;
  logic [XW-1:0]         x, col_cnt;
  logic [YW-1:0]         y, row_cnt;
  logic [CW-1:0]         col_band, row_band, offset;
  logic [ADDR_WIDTH-1:0] expected;
  logic [1:0]            mode_q;
  logic [7:0]            pipe_data [LATENCY];
  logic                  pipe_valid [LATENCY];

  logic                  addr_zero, in_range, start, advance, frame_done, set_err;
  logic [1:0]            eff_mode;
  logic [XW-1:0]         eff_x;
  logic [YW-1:0]         eff_y;
  logic [CW-1:0]         eff_band, pal_idx;
  logic [CW:0]           band_sum;
  logic [15:0]           pattern;
  logic [7:0]            out_byte;

  function automatic logic [15:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'hF800;
      4'd1:    return 16'hFBE0;
      4'd2:    return 16'hFFE0;
      4'd3:    return 16'h7FE0;
      4'd4:    return 16'h07E0;
      4'd5:    return 16'h07EF;
      4'd6:    return 16'h07FF;
      4'd7:    return 16'h03FF;
      4'd8:    return 16'h001F;
      4'd9:    return 16'h781F;
      4'd10:   return 16'hF81F;
      default: return 16'hF80F;
    endcase
  endfunction

  function automatic logic [7:0] pick(input logic [15:0] c, input logic odd);
    return odd ? c[7:0] : c[15:8];
  endfunction

  // A frame-start request sees cleared counters and the live mode input.
  always_comb begin
    addr_zero = (mem_addr == '0);
    in_range  = (mem_addr < ADDR_WIDTH'(FRAME_BYTES));
    eff_mode  = addr_zero ? mode : mode_q;
    eff_x     = addr_zero ? '0 : x;
    eff_y     = addr_zero ? '0 : y;
    eff_band  = '0;
    if (!addr_zero) eff_band = (eff_mode == 2'd1) ? col_band : row_band;
    band_sum = {1'b0, eff_band} + {1'b0, offset};
    pal_idx  = (band_sum >= CW1'(NUM_COLORS)) ? CW'(band_sum - CW1'(NUM_COLORS)) : CW'(band_sum);
    case (eff_mode)
      2'd0, 2'd1: pattern = palette(4'(pal_idx));
      2'd2:       pattern = ((1'(eff_x >> CHECKER_SHIFT) ^ 1'(eff_y >> CHECKER_SHIFT)) == offset[0])
                            ? 16'hFFFF : 16'h0000;
      default:    pattern = solid_color;
    endcase
  end

  always_comb begin
    state_next = state;
    out_byte   = 8'h00;
    start      = 1'b0;
    advance    = 1'b0;
    frame_done = 1'b0;
    set_err    = 1'b0;
    if (mem_req) begin
      if (!in_range) begin
        if (state == RUN) begin
          set_err    = 1'b1;
          state_next = ERROR;
        end
      end else if (addr_zero) begin
        start      = 1'b1;
        out_byte   = pick(pattern, 1'b0);
        state_next = RUN;
      end else begin
        case (state)
          SYNC: state_next = SYNC;
          RUN: begin
            if (mem_addr == expected) begin
              out_byte = pick(pattern, mem_addr[0]);
              advance  = 1'b1;
              if (mem_addr == ADDR_WIDTH'(FRAME_BYTES - 1)) begin
                frame_done = 1'b1;
                state_next = SYNC;
              end
            end else begin
              set_err    = 1'b1;
              out_byte   = pick(ERROR_COLOR, mem_addr[0]);
              state_next = ERROR;
            end
          end
          ERROR:   out_byte = pick(ERROR_COLOR, mem_addr[0]);
          default: state_next = SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      x           <= '0;
      y           <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      col_band    <= '0;
      row_band    <= '0;
      offset      <= '0;
      expected    <= '0;
      mode_q      <= 2'd0;
      seq_error   <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      state <= state_next;
      if (start) begin
        x        <= '0;
        y        <= '0;
        col_cnt  <= '0;
        row_cnt  <= '0;
        col_band <= '0;
        row_band <= '0;
        mode_q   <= mode;
        expected <= ADDR_WIDTH'(1);
      end else if (advance) begin
        expected <= expected + ADDR_WIDTH'(1);
        // Pixel position only moves after the low byte of each pixel.
        if (mem_addr[0]) begin
          if (x == XW'(FB_WIDTH - 1)) begin
            x        <= '0;
            col_cnt  <= '0;
            col_band <= '0;
            y        <= (y == YW'(FB_HEIGHT - 1)) ? '0 : y + YW'(1);
            if (row_cnt == YW'(ROWS_PER_BAND - 1)) begin
              row_cnt <= '0;
              if (row_band != CW'(NUM_COLORS - 1)) row_band <= row_band + CW'(1);
            end else begin
              row_cnt <= row_cnt + YW'(1);
            end
          end else begin
            x <= x + XW'(1);
            if (col_cnt == XW'(COLS_PER_BAND - 1)) begin
              col_cnt <= '0;
              if (col_band != CW'(NUM_COLORS - 1)) col_band <= col_band + CW'(1);
            end else begin
              col_cnt <= col_cnt + XW'(1);
            end
          end
        end
      end
      if (set_err) seq_error <= 1'b1;
      if (frame_done) begin
        frame_count <= frame_count + 16'd1;
        if (animate) offset <= (offset == CW'(NUM_COLORS - 1)) ? '0 : offset + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i]  <= 8'h00;
        pipe_valid[i] <= 1'b0;
      end
    end else begin
      pipe_data[0]  <= mem_req ? out_byte : 8'h00;
      pipe_valid[0] <= mem_req;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_data[i]  <= pipe_data[i-1];
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  assign mem_out   = pipe_data[LATENCY-1];
  assign mem_ready = pipe_valid[LATENCY-1];

endmodule

// File: tb/tb_pattern_mem_generator.sv
// tb/tb_pattern_mem_generator.sv - scoreboard bench for pattern_mem_generator
// covering patterns, animation, latency flush and sequence errors.
module tb_pattern_mem_generator;

  logic        clk = 1'b0;
  logic        reset_a, reset_b, reset_c;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  mode;
  logic        animate;
  logic [15:0] solid_color;

  logic [7:0]  a_out, b_out, c_out;
  logic        a_ready, b_ready, c_ready;
  logic        a_err, b_err, c_err;
  logic [15:0] a_fc, b_fc, c_fc;

  always #5 clk = ~clk;

  pattern_mem_generator dut_a (
    .clk(clk), .reset(reset_a), .mem_req(mem_req), .mem_addr(mem_addr), .mode(mode),
    .animate(animate), .solid_color(solid_color), .mem_out(a_out), .mem_ready(a_ready),
    .seq_error(a_err), .frame_count(a_fc));

  pattern_mem_generator #(.LATENCY(3)) dut_b (
    .clk(clk), .reset(reset_b), .mem_req(mem_req), .mem_addr(mem_addr), .mode(mode),
    .animate(animate), .solid_color(solid_color), .mem_out(b_out), .mem_ready(b_ready),
    .seq_error(b_err), .frame_count(b_fc));

  pattern_mem_generator #(.FB_WIDTH(12), .FB_HEIGHT(12)) dut_c (
    .clk(clk), .reset(reset_c), .mem_req(mem_req), .mem_addr(mem_addr), .mode(mode),
    .animate(animate), .solid_color(solid_color), .mem_out(c_out), .mem_ready(c_ready),
    .seq_error(c_err), .frame_count(c_fc));

  typedef struct {
    int         addr;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] seen [int];
  int         passed = 0;
  int         total = 0;
  int         ready_count = 0;
  int         sel = 0;
  int         off = 0;
  logic       mon_ready;
  logic [7:0] mon_out;

  logic [15:0] pal [12] = '{16'hF800, 16'hFBE0, 16'hFFE0, 16'h7FE0, 16'h07E0, 16'h07EF,
                            16'h07FF, 16'h03FF, 16'h001F, 16'h781F, 16'hF81F, 16'hF80F};

  always_comb begin
    mon_ready = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
    mon_out   = (sel == 0) ? a_out : (sel == 1) ? b_out : c_out;
  end

  // Reference pixel colour from the absolute address, using plain division.
  function automatic logic [7:0] model(input int addr, input int md, input int o,
                                       input int w, input int h);
    int p, x, y, rb, cb;
    logic [15:0] c;
    p  = addr / 2;
    x  = p % w;
    y  = p / w;
    rb = y / (h / 12);
    cb = x / (w / 12);
    if (rb > 11) rb = 11;
    if (cb > 11) cb = 11;
    case (md)
      0:       c = pal[(rb + o) % 12];
      1:       c = pal[(cb + o) % 12];
      2:       c = ((((x >> 3) ^ (y >> 3)) & 1) == (o & 1)) ? 16'hFFFF : 16'h0000;
      default: c = solid_color;
    endcase
    return (addr % 2 == 1) ? c[7:0] : c[15:8];
  endfunction

  always @(negedge clk) begin
    if (mon_ready) begin
      exp_t e;
      ready_count++;
      total++;
      assert (exp_q.size() != 0) passed++;
      else $error("FAIL sb_spurious_ready: observed ready=1 with nothing pending, expected ready=0");
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        seen[e.addr] = mon_out;
        total++;
        assert (mon_out === e.b) passed++;
        else $error("FAIL sb_byte addr=%0d: observed %02h expected %02h", e.addr, mon_out, e.b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input int addr, input logic [7:0] e);
    @(posedge clk); #1;
    mem_req  = 1'b1;
    mem_addr = addr;
    exp_q.push_back('{addr, e});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_range(input int first, input int last, input int md, input int o,
                            input int w, input int h);
    for (int a = first; a <= last; a++) send(a, model(a, md, o, w, h));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    mem_req = 1'b0; mem_addr = 0; mode = 2'd0; animate = 1'b0; solid_color = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_out", a_out, 0);
    check("reset_mem_ready", a_ready, 0);
    check("reset_seq_error", a_err, 0);
    check("reset_frame_count", a_fc, 0);
    @(posedge clk); #1;
    reset_a = 1'b0;

    // SYNC ignores non-zero and out-of-range addresses without flagging errors
    send(5, 8'h00);
    send(9600, 8'h00);
    idle();
    drain("drain_sync");
    check("sync_no_error", a_err, 0);

    // Mode 0, one full frame
    seen.delete();
    ready_count = 0;
    send_range(0, 9599, 0, 0, 80, 60);
    idle();
    drain("drain_mode0");
    check("mode0_ready_count", ready_count, 9600);
    check("mode0_frame_count", a_fc, 1);
    check("mode0_a0", seen[0], 8'hF8);
    check("mode0_a1", seen[1], 8'h00);
    check("mode0_row5", seen[800], 8'hFB);
    check("mode0_row57_hi", seen[9120], 8'hF8);
    check("mode0_row57_lo", seen[9121], 8'h0F);
    send(9600, 8'h00);
    send(1, 8'h00);
    idle();
    drain("drain_after_frame");
    check("after_frame_no_error", a_err, 0);

    // Mode 1 partial frame; a mode change mid-frame must be ignored
    seen.delete();
    mode = 2'd1;
    for (int a = 0; a < 160; a++) begin
      if (a == 80) mode = 2'd2;
      send(a, model(a, 1, 0, 80, 60));
    end
    idle();
    drain("drain_mode1");
    check("mode1_x6_hi", seen[12], 8'hFB);
    check("mode1_x6_lo", seen[13], 8'hE0);
    check("mode1_x72_hi", seen[144], 8'hF8);
    check("mode1_x72_lo", seen[145], 8'h0F);
    check("mode1_x79_lo", seen[159], 8'h0F);

    // Mode 2 checkerboard, restarted from RUN
    seen.delete();
    send_range(0, 1299, 2, 0, 80, 60);
    idle();
    drain("drain_mode2");
    check("mode2_0_0", {seen[0], seen[1]}, 16'hFFFF);
    check("mode2_8_0", {seen[16], seen[17]}, 16'h0000);
    check("mode2_8_8", {seen[1296], seen[1297]}, 16'hFFFF);

    // Mode 3 solid colour
    seen.delete();
    mode = 2'd3;
    solid_color = 16'h1234;
    send_range(0, 3, 3, 0, 80, 60);
    idle();
    drain("drain_mode3");
    check("mode3_hi", seen[2], 8'h12);
    check("mode3_lo", seen[3], 8'h34);
    check("mode3_frame_count", a_fc, 1);

    // Sequence error and recovery
    seen.delete();
    mode = 2'd0;
    send(0, 8'hF8);
    send(1, 8'h00);
    send(2, 8'hF8);
    send(10, 8'hF8);
    send(11, 8'h1F);
    send(12, 8'hF8);
    send(0, 8'hF8);
    send(1, 8'h00);
    idle();
    drain("drain_error");
    check("error_sticky", a_err, 1);
    check("error_byte_11", seen[11], 8'h1F);

    // LATENCY=3 instance: reset flushes in-flight requests
    @(posedge clk); #1;
    reset_a = 1'b1;
    sel = 1;
    reset_b = 1'b0;
    ready_count = 0;
    send(0, 8'hF8);
    send(1, 8'h00);
    send(2, 8'hF8);
    @(posedge clk); #1;
    mem_req = 1'b0;
    reset_b = 1'b1;
    repeat (6) @(negedge clk);
    check("lat3_ready_count", ready_count, 1);
    check("lat3_dropped", exp_q.size(), 2);
    exp_q.delete();
    check("lat3_mem_out", b_out, 0);
    check("lat3_mem_ready", b_ready, 0);
    check("lat3_seq_error", b_err, 0);
    check("lat3_frame_count", b_fc, 0);

    // Small-frame instance: animation over 13 frames, then hold with animate=0
    sel = 2;
    @(posedge clk); #1;
    reset_c = 1'b0;
    mode = 2'd0;
    animate = 1'b1;
    off = 0;
    for (int f = 0; f < 13; f++) begin
      seen.delete();
      send_range(0, 287, 0, off, 12, 12);
      idle();
      drain("drain_anim");
      if (f == 1) check("anim_frame2_a0", seen[0], 8'hFB);
      if (f == 12) check("anim_frame13_a0", seen[0], 8'hF8);
      off = (off + 1) % 12;
    end
    check("anim_frame_count", c_fc, 13);
    animate = 1'b0;
    for (int f = 0; f < 2; f++) begin
      seen.delete();
      send_range(0, 287, 0, off, 12, 12);
      idle();
      drain("drain_hold");
    end
    check("hold_offset_a0", seen[0], 8'hFB);
    check("hold_frame_count", c_fc, 15);
    check("anim_no_error", c_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
